sparse_mac_scheduler: RTL

- Sequences one sparse-aware MAC processing element (PE) through an N-element dot product.
- Holds two small operand buffers, m1 and m2, and walks the element index.
- Skips elements whose m2 operand is zero without issuing them to the PE.
- Feeds the PE result co1 back as the next c1, and reports the final 9-bit accumulation plus issue/skip statistics.

---
 rtl/sparse_mac_pkg.sv | 27 ++
 rtl/sparse_operand_buf.sv | 34 +++
 rtl/sparse_mac_scheduler.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/sparse_mac_pkg.sv
// Shared types and constants for the sparse MAC scheduler.
// Also holds the PE arithmetic helper used to model the processing element.
package sparse_mac_pkg;

  localparam int unsigned OPW  = 8;
  localparam int unsigned ACCW = 9;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  // Product wraps at 256, sum wraps at 512.
  function automatic logic [ACCW-1:0] pe_model(
    input logic [OPW-1:0]  a,
    input logic [OPW-1:0]  b,
    input logic [ACCW-1:0] c
  );
    logic [2*OPW-1:0] p;
    p = a * b;
    return {1'b0, p[OPW-1:0]} + c;
  endfunction

endpackage

// File: rtl/sparse_operand_buf.sv
// Two DEPTH x 8 operand register arrays with one write port
// and a combinational read at the scan index.
module sparse_operand_buf
  import sparse_mac_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic           clk,
  input  logic           we,
  input  logic           sel,
  input  logic [AW-1:0]  waddr,
  input  logic [OPW-1:0] wdata,
  input  logic [AW-1:0]  raddr,
  output logic [OPW-1:0] m1,
  output logic [OPW-1:0] m2,
  output logic           m2_zero
);

  logic [OPW-1:0] m1_mem [DEPTH];
  logic [OPW-1:0] m2_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      if (sel) m2_mem[waddr] <= wdata;
      else     m1_mem[waddr] <= wdata;
    end
  end

  assign m1      = m1_mem[raddr];
  assign m2      = m2_mem[raddr];
  assign m2_zero = (m2 == '0);

endmodule

// File: rtl/sparse_mac_scheduler.sv
// Walks an N-element dot product through one MAC PE,
// skipping zero m2 operands and chaining co1 back into c1.
module sparse_mac_scheduler
  import sparse_mac_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AW        = 3,
  parameter int unsigned SKIP_ZERO = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic            wr_sel,
  input  logic [AW-1:0]   wr_addr,
  input  logic [OPW-1:0]  wr_data,
  input  logic            start,
  input  logic [AW:0]     len,
  output logic            busy,
  output logic            done,
  output logic [ACCW-1:0] result,
  output logic [AW:0]     mac_cnt,
  output logic [AW:0]     skip_cnt,
  output logic [OPW-1:0]  pe_m1x,
  output logic [OPW-1:0]  pe_m2x,
  output logic [ACCW-1:0] pe_c1,
  output logic            pe_f,
  input  logic [ACCW-1:0] pe_co1
);

  localparam logic [AW:0] ONE   = (AW+1)'(1);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  state_t          state_q, state_d;
  logic [AW:0]     idx_q;
  logic [AW:0]     len_q;
  logic [ACCW-1:0] acc_q;
  logic [OPW-1:0]  m1, m2;
  logic            m2_zero;
  logic            we;
  logic            at_end;
  logic            skip;

  assign we     = wr_en && (state_q == IDLE);
  assign at_end = (idx_q == len_q);
  assign skip   = (SKIP_ZERO != 0) && m2_zero;

  sparse_operand_buf #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .we      (we),
    .sel     (wr_sel),
    .waddr   (wr_addr),
    .wdata   (wr_data),
    .raddr   (idx_q[AW-1:0]),
    .m1      (m1),
    .m2      (m2),
    .m2_zero (m2_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN: begin
        if (at_end)    state_d = DONE;
        else if (skip) state_d = SCAN;
        else           state_d = ISSUE;
      end
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = SCAN;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      len_q    <= '0;
      acc_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      mac_cnt  <= '0;
      skip_cnt <= '0;
      pe_m1x   <= '0;
      pe_m2x   <= '0;
      pe_c1    <= '0;
      pe_f     <= 1'b0;
    end else begin
      // PE operands only carry data during ISSUE.
      pe_f   <= 1'b0;
      pe_m1x <= '0;
      pe_m2x <= '0;
      pe_c1  <= '0;
      done   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            len_q    <= (len > DEPTH_L) ? DEPTH_L : len;
            idx_q    <= '0;
            acc_q    <= '0;
            mac_cnt  <= '0;
            skip_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        SCAN: begin
          if (!at_end) begin
            if (skip) begin
              skip_cnt <= skip_cnt + ONE;
              idx_q    <= idx_q + ONE;
            end else begin
              pe_f   <= 1'b1;
              pe_m1x <= m1;
              pe_m2x <= m2;
              pe_c1  <= acc_q;
            end
          end
        end
        ISSUE: mac_cnt <= mac_cnt + ONE;
        WAIT: begin
          acc_q <= pe_co1;
          idx_q <= idx_q + ONE;
        end
        DONE: begin
          result <= acc_q;
          done   <= 1'b1;
          busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
